// File: rtl/rotate_detect.sv
`default_nettype none
// ============================================================================
// Module   : rotate_detect
// Purpose  : Sequential search for the shortest left/right rotation that maps
//            one word onto another, testing one candidate rotation per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rotate_detect #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] original,
    input  logic [WIDTH-1:0] rotated,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [AW-1:0]    amount,
    output logic             right_not_left
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [AW:0]   c_WIDTH = (AW+1)'(WIDTH);
    localparam logic [AW-1:0] c_HALF  = AW'(WIDTH / 2);
    localparam logic [AW-1:0] c_KMAX  = AW'(WIDTH - 1);
    localparam logic [AW-1:0] c_ONE   = AW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_tgt;
    logic [AW-1:0]    r_k;
    logic             r_found;
    logic [AW-1:0]    r_amount;
    logic             r_rnl;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cand_nxt;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic [AW-1:0]    w_k_nxt;
    logic             w_found_nxt;
    logic [AW-1:0]    w_amount_nxt;
    logic             w_rnl_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cand   <= '0;
            r_tgt    <= '0;
            r_k      <= '0;
            r_found  <= 1'b0;
            r_amount <= '0;
            r_rnl    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cand   <= w_cand_nxt;
            r_tgt    <= w_tgt_nxt;
            r_k      <= w_k_nxt;
            r_found  <= w_found_nxt;
            r_amount <= w_amount_nxt;
            r_rnl    <= w_rnl_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_tgt_nxt    = r_tgt;
        w_k_nxt      = r_k;
        w_found_nxt  = r_found;
        w_amount_nxt = r_amount;
        w_rnl_nxt    = r_rnl;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SEARCH;
                    w_cand_nxt  = original;
                    w_tgt_nxt   = rotated;
                    w_k_nxt     = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEARCH: begin
                if (r_cand == r_tgt) begin
                    // Left distances past the halfway point are reported as the shorter right rotation.
                    w_state_nxt = S_DONE;
                    w_found_nxt = 1'b1;
                    if (r_k > c_HALF) begin
                        w_amount_nxt = AW'(c_WIDTH - {1'b0, r_k});
                        w_rnl_nxt    = 1'b1;
                    end else begin
                        w_amount_nxt = r_k;
                        w_rnl_nxt    = 1'b0;
                    end
                end else if (r_k == c_KMAX) begin
                    w_state_nxt  = S_DONE;
                    w_found_nxt  = 1'b0;
                    w_amount_nxt = '0;
                    w_rnl_nxt    = 1'b0;
                end else begin
                    w_cand_nxt = {r_cand[WIDTH-2:0], r_cand[WIDTH-1]};
                    w_k_nxt    = r_k + c_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy           = (r_state == S_SEARCH);
    assign done           = (r_state == S_DONE);
    assign found          = r_found;
    assign amount         = r_amount;
    assign right_not_left = r_rnl;

endmodule
`default_nettype wire

// File: doc/rotate_detect.md
ROTATE_DETECT -- requirements
Module: rotate_detect

Interface
REQ-001 WIDTH, 8, data width; SHALL be a power of two, 4 to 32; AW = log2(WIDTH).
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 original  input  WIDTH  unrotated word; sampled on the accepted start edge.
REQ-006 rotated  input  WIDTH  rotated word; sampled on the accepted start edge.
REQ-007 busy  output  1  high in SEARCH only.
REQ-008 done  output  1  single-cycle pulse, high in DONE only.
REQ-009 found  output  1  1 = a rotation maps original to rotated.
REQ-010 amount  output  AW  rotation distance, 0 to WIDTH/2.
REQ-011 right_not_left  output  1  1 = right rotation, 0 = left rotation.

Function
REQ-012 FSM SHALL have three states: IDLE, SEARCH and DONE; it SHALL be one-hot or binary, with no other reachable states.
REQ-013 IDLE or DONE with start=1 SHALL go to SEARCH and load the working registers:
- cand <= original
- tgt <= rotated
- k <= 0
REQ-014 DONE with start=0 SHALL go to IDLE; IDLE with start=0 SHALL stay in IDLE.
REQ-015 start asserted in SEARCH SHALL be ignored: no restart and no effect on inputs or results.
REQ-016 Each SEARCH cycle SHALL compare cand with tgt:
- match: go to DONE, found <= 1, and result from k per REQ-018
- no match with k = WIDTH-1: go to DONE, found <= 0, amount <= 0, right_not_left <= 0
- otherwise: cand <= cand rotated left by one bit, k <= k+1
REQ-017 The first match SHALL win: the smallest left distance k is reported. Periodic patterns such as 0x55 and 0x00 resolve to the minimal k.
REQ-018 Result mapping from k:
- k = 0: amount = 0, right_not_left = 0
- 1 <= k <= WIDTH/2: amount = k, right_not_left = 0 (tie at WIDTH/2 reports left)
- k > WIDTH/2: amount = WIDTH-k, right_not_left = 1
REQ-019 found, amount and right_not_left SHALL update only on the edge entering DONE and SHALL hold until the next DONE entry.
REQ-020 Latency: a match at distance k SHALL give done high in cycle k+2, counting the accepted start edge as cycle 1. No match SHALL give done in cycle WIDTH+1.
REQ-021 Inputs SHALL be ignored outside the accepted start edge; they may change during SEARCH without effect.
REQ-022 Back-to-back operation: start in the DONE cycle SHALL be accepted with no dead cycle.
REQ-023 The module SHALL contain no combinational path from any input to any output; all outputs SHALL be registered or decoded from state.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for clk, set:
- state = IDLE
- busy = 0, done = 0, found = 0
- amount = 0, right_not_left = 0
- cand = 0, tgt = 0, k = 0
REQ-025 Reset asserted mid-SEARCH SHALL abort the search with no done pulse; after release, the first start edge SHALL begin a fresh search.
REQ-026 The first rising clk edge after reset deassertion SHALL sample start normally.

Verification
REQ-027 original=0x96, rotated=0xB4, start for 1 cycle:
- busy high for 4 cycles
- done in cycle 5
- found=1, amount=3, right_not_left=0
REQ-028 original=0x96, rotated=0xA5:
- done in cycle 8
- found=1, amount=2, right_not_left=1
REQ-029 Non-rotation and periodic inputs:
- original=0x96, rotated=0x97: done in cycle 9, found=0, amount=0
- original=0x55, rotated=0xAA: found=1, amount=1, right_not_left=0
- original=0x3C, rotated=0x3C: done in cycle 2, amount=0
REQ-030 Start held high through the whole search:
- no restart during SEARCH
- after done, immediate re-accept in the DONE cycle with new operands 0x01/0x80: amount=1, right_not_left=1
REQ-031 Reset asserted during cycle 3 of a 0x96/0xA5 search:
- outputs clear asynchronously, no done pulse
- a subsequent 0x96/0xB4 search completes per REQ-027
